// File: rtl/clkgate_ctrl_pkg.sv
// State encoding and counter widths shared by the clock-gating idle controller
// and its testbench.
package clkgate_ctrl_pkg;

    typedef enum logic [1:0] {
        ON        = 2'd0,
        IDLE_WAIT = 2'd1,
        OFF       = 2'd2,
        WAKE      = 2'd3
    } cg_state_e;

    localparam int GATED_CNT_W = 32;
    localparam int WAKE_CNT_W  = 4;

endpackage

// File: rtl/generic_clkgate.sv
// Latch-based integrated clock gate: the enable is sampled only while clk is
// low, so clk_out can never produce a runt pulse.
module generic_clkgate (
    input  logic clk,
    input  logic en,
    input  logic te,
    output logic clk_out
);

    logic enLatch;

    always_latch begin
        if (!clk) begin
            enLatch = en | te;
        end
    end

    assign clk_out = clk & enLatch;

endmodule

// File: rtl/clkgate_idle_ctrl.sv
// Idle-driven clock-gating controller: gates the downstream clock after a
// programmable idle period and restores it on request, acknowledging requesters.
module clkgate_idle_ctrl
    import clkgate_ctrl_pkg::*;
#(
    parameter int NUM_REQ     = 4,
    parameter int IDLE_CNT_W  = 8,
    parameter int WAKE_CYCLES = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   te,
    input  logic                   force_on,
    input  logic [IDLE_CNT_W-1:0]  idle_thresh,
    input  logic                   busy,
    input  logic [NUM_REQ-1:0]     req,
    output logic [NUM_REQ-1:0]     ack,
    output logic                   gclk_out,
    output logic                   clk_en,
    output logic [1:0]             state,
    output logic [GATED_CNT_W-1:0] gated_cycles
);

    localparam logic [WAKE_CNT_W-1:0] WakeLast = WAKE_CNT_W'(WAKE_CYCLES - 1);

    cg_state_e               stateQ, stateD;
    logic [IDLE_CNT_W-1:0]   idleCntQ, idleCntD;
    logic [WAKE_CNT_W-1:0]   wakeCntQ, wakeCntD;
    logic [NUM_REQ-1:0]      ackQ, ackD;
    logic [GATED_CNT_W-1:0]  gatedQ, gatedD;
    logic                    clkEnQ, clkEnD;
    logic                    anyReq;

    assign anyReq = |req;

    // Wake-up causes outrank idle expiry in IDLE_WAIT; busy cannot wake OFF.
    always_comb begin
        stateD   = stateQ;
        idleCntD = idleCntQ;
        wakeCntD = wakeCntQ;
        case (stateQ)
            ON: begin
                idleCntD = '0;
                if (!anyReq && !busy && !force_on) begin
                    stateD = IDLE_WAIT;
                end
            end
            IDLE_WAIT: begin
                if (anyReq || busy || force_on) begin
                    stateD   = ON;
                    idleCntD = '0;
                end else begin
                    if (idleCntQ >= idle_thresh) begin
                        stateD = OFF;
                    end
                    if (idleCntQ != '1) begin
                        idleCntD = idleCntQ + 1'b1;
                    end
                end
            end
            OFF: begin
                if (anyReq || force_on) begin
                    stateD   = WAKE;
                    wakeCntD = '0;
                end
            end
            WAKE: begin
                if (wakeCntQ >= WakeLast) begin
                    stateD   = ON;
                    wakeCntD = '0;
                end else begin
                    wakeCntD = wakeCntQ + 1'b1;
                end
            end
            default: begin
                stateD = ON;
            end
        endcase
    end

    always_comb begin
        ackD   = (stateQ == ON) ? req : '0;
        clkEnD = (stateD != OFF);
        gatedD = gatedQ;
        if (stateQ == OFF && gatedQ != '1) begin
            gatedD = gatedQ + 1'b1;
        end
    end

    // Reset re-enables the clock at once so the gated domain sees its own reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stateQ   <= ON;
            idleCntQ <= '0;
            wakeCntQ <= '0;
            ackQ     <= '0;
            gatedQ   <= '0;
            clkEnQ   <= 1'b1;
        end else begin
            stateQ   <= stateD;
            idleCntQ <= idleCntD;
            wakeCntQ <= wakeCntD;
            ackQ     <= ackD;
            gatedQ   <= gatedD;
            clkEnQ   <= clkEnD;
        end
    end

    assign ack          = ackQ;
    assign clk_en       = clkEnQ;
    assign state        = stateQ;
    assign gated_cycles = gatedQ;

    generic_clkgate u_gate (
        .clk     (clk),
        .en      (clkEnQ),
        .te      (te),
        .clk_out (gclk_out)
    );

endmodule
